sw_matrix_scheduler: RTL and testbench

- Queues crosspoint commands for the six MT8816 switch drivers and issues them one at a time on the shared SW_AX/SW_AY/SW_DATA/SW_CLEAR bus.
- Sits between the MUX instruction decoder and the MT8816 driver instances.
- Generates a one-cycle enable for each targeted chip, or for all chips on broadcast.
- Holds the shared bus stable until every targeted driver reports idle, so the MUX never has to poll SW_IDLE itself.

---
 rtl/sw_matrix_scheduler_if.sv | 33 +++
 rtl/sw_matrix_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_sw_matrix_scheduler.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/sw_matrix_scheduler_if.sv
// Command and switch-bus bundle between the MUX decoder, the crosspoint
// scheduler and the MT8816 driver bank.
`timescale 1ns/1ps
interface sw_matrix_scheduler_if #(
    parameter int N_SW = 6
);
    logic            CMD_VALID_I;
    logic            CMD_READY_O;
    logic [11:0]     CMD_I;
    logic [N_SW-1:0] SW_IDLE_IS;
    logic [N_SW-1:0] SW_EN_OS;
    logic            SW_CLEAR_O;
    logic [3:0]      SW_AX_O;
    logic [2:0]      SW_AY_O;
    logic            SW_DATA_O;
    logic            IDLE_O;
    logic            ERR_O;
    logic [15:0]     DONE_CNT_O;

    // scheduler side
    modport slave (
        input  CMD_VALID_I, CMD_I, SW_IDLE_IS,
        output CMD_READY_O, SW_EN_OS, SW_CLEAR_O, SW_AX_O, SW_AY_O, SW_DATA_O,
               IDLE_O, ERR_O, DONE_CNT_O
    );

    // decoder / driver-bank side
    modport master (
        output CMD_VALID_I, CMD_I, SW_IDLE_IS,
        input  CMD_READY_O, SW_EN_OS, SW_CLEAR_O, SW_AX_O, SW_AY_O, SW_DATA_O,
               IDLE_O, ERR_O, DONE_CNT_O
    );
endinterface

// File: rtl/sw_matrix_scheduler.sv
// Crosspoint command scheduler for the MT8816 driver bank.
// Commands are queued in a small FIFO and issued one at a time on the shared
// AX/AY/DATA/CLEAR bus; the bus is held until every targeted driver is idle.
// Optional macro SW_TIMEOUT_EN: abandon a command whose targets never return
// idle within TIMEOUT_CYC cycles and flag ERR_O.
`timescale 1ns/1ps
module sw_matrix_scheduler #(
    parameter int N_SW        = 6,
    parameter int FIFO_DEPTH  = 8,
    parameter int GUARD_CYC   = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                 FPGA_CLK_I,
    input  logic                 RESET_N_I,
    sw_matrix_scheduler_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int GW = $clog2(GUARD_CYC + 1);
    localparam logic [GW-1:0] G_LAST = GW'(GUARD_CYC - 1);

    // elaboration-time parameter sanity
    if (N_SW < 1 || N_SW > 7) begin : g_bad_nsw
        $error("N_SW must be 1..7");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2, >= 2");
    end
    if (GUARD_CYC < 1) begin : g_bad_guard
        $error("GUARD_CYC must be >= 1");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_tmo
        $error("TIMEOUT_CYC must be 1..65535");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GUARD, S_WAIT} state_t;

    state_t          state_q, state_d;
    logic [11:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            full, empty, push, pop;
    logic            latch, err_set, done_inc;
    logic [11:0]     head;
    logic [2:0]      head_chip;
    logic [N_SW-1:0] head_mask, mask_q, en_q;
    logic            head_ok;
    logic [GW-1:0]   g_cnt;
    logic            err_q, idle_q;
    logic [15:0]     done_q;
    logic            clr_q, data_q;
    logic [3:0]      ax_q;
    logic [2:0]      ay_q;

`ifdef SW_TIMEOUT_EN
    localparam logic [15:0] TMO_LIM = 16'(TIMEOUT_CYC - 1);
    logic [15:0] tmo_cnt;
`endif

    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign push      = bus.CMD_VALID_I && !full;
    assign head      = mem[rd_ptr];
    assign head_chip = head[11:9];

    assign bus.CMD_READY_O = !full;
    assign bus.SW_EN_OS    = en_q;
    assign bus.SW_CLEAR_O  = clr_q;
    assign bus.SW_AX_O     = ax_q;
    assign bus.SW_AY_O     = ay_q;
    assign bus.SW_DATA_O   = data_q;
    assign bus.IDLE_O      = idle_q;
    assign bus.ERR_O       = err_q;
    assign bus.DONE_CNT_O  = done_q;

    // decode head chip index into a target mask; 7 broadcasts
    always_comb begin
        head_mask = '0;
        head_ok   = 1'b0;
        if (head_chip == 3'd7) begin
            head_mask = '1;
            head_ok   = 1'b1;
        end else if (int'(head_chip) < N_SW) begin
            head_mask = N_SW'(1) << head_chip;
            head_ok   = 1'b1;
        end
    end

    // next state and per-cycle control strobes
    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        latch    = 1'b0;
        err_set  = 1'b0;
        done_inc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    if (!head_ok) begin
                        pop     = 1'b1;
                        err_set = 1'b1;
                    end else if ((bus.SW_IDLE_IS & head_mask) == head_mask) begin
                        pop     = 1'b1;
                        latch   = 1'b1;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: state_d = S_GUARD;
            S_GUARD: if (g_cnt == G_LAST) state_d = S_WAIT;
            S_WAIT: begin
                if ((bus.SW_IDLE_IS & mask_q) == mask_q) begin
                    done_inc = 1'b1;
                    state_d  = S_IDLE;
                end
`ifdef SW_TIMEOUT_EN
                else if (tmo_cnt >= TMO_LIM) begin
                    err_set = 1'b1;
                    state_d = S_IDLE;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // queue storage; contents are don't-care while the queue is empty
    always_ff @(posedge FPGA_CLK_I) begin
        if (push) mem[wr_ptr] <= bus.CMD_I;
    end

    // FSM, queue pointers and registered outputs
    always_ff @(posedge FPGA_CLK_I or negedge RESET_N_I) begin
        if (!RESET_N_I) begin
            state_q <= S_IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            mask_q  <= '0;
            en_q    <= '0;
            g_cnt   <= '0;
            err_q   <= 1'b0;
            idle_q  <= 1'b1;
            done_q  <= '0;
            clr_q   <= 1'b0;
            ax_q    <= '0;
            ay_q    <= '0;
            data_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (latch) begin
                mask_q <= head_mask;
                clr_q  <= head[8];
                ax_q   <= head[7:4];
                ay_q   <= head[3:1];
                data_q <= head[0];
            end
            // enable is registered so the shared bus has settled a full cycle
            // before any driver samples it
            en_q  <= (state_q == S_ISSUE) ? mask_q : '0;
            g_cnt <= (state_q == S_GUARD) ? g_cnt + 1'b1 : '0;
            if (err_set)  err_q  <= 1'b1;
            if (done_inc) done_q <= done_q + 1'b1;
            idle_q <= (state_q == S_IDLE) && empty;
        end
    end

`ifdef SW_TIMEOUT_EN
    // per-command watchdog across guard and wait, saturating
    always_ff @(posedge FPGA_CLK_I or negedge RESET_N_I) begin
        if (!RESET_N_I) begin
            tmo_cnt <= '0;
        end else if (state_q == S_GUARD || state_q == S_WAIT) begin
            if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_sw_matrix_scheduler.sv
// Scoreboard bench for sw_matrix_scheduler: expected bus transactions are
// queued as commands are driven and checked when an enable pulse appears.
`timescale 1ns/1ps
module tb_sw_matrix_scheduler;
    localparam int N_SW = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sw_matrix_scheduler_if #(.N_SW(N_SW)) bus ();

    sw_matrix_scheduler #(
        .N_SW(N_SW), .FIFO_DEPTH(8), .GUARD_CYC(2), .TIMEOUT_CYC(16)
    ) dut (
        .FPGA_CLK_I(clk),
        .RESET_N_I (rst_n),
        .bus       (bus)
    );

    typedef struct packed {
        logic [5:0] en;
        logic       clr;
        logic [3:0] ax;
        logic [2:0] ay;
        logic       d;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_pops  = 0;
    logic [5:0] prev_en = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [11:0] c);
        exp_t e;
        e.en  = (c[11:9] == 3'd7) ? 6'h3F : (6'd1 << c[11:9]);
        e.clr = c[8];
        e.ax  = c[7:4];
        e.ay  = c[3:1];
        e.d   = c[0];
        return e;
    endfunction

    // enable monitor: every pulse must be one cycle wide and match the scoreboard head
    always @(negedge clk) begin
        if (rst_n && bus.SW_EN_OS != '0) begin
            chk("en_pulse_len", 32'(prev_en), 32'h0);
            if (sb.size() == 0) begin
                chk("en_unexpected", 32'(bus.SW_EN_OS), 32'h0);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_en",   32'(bus.SW_EN_OS),   32'(mon_e.en));
                chk("sb_ax",   32'(bus.SW_AX_O),    32'(mon_e.ax));
                chk("sb_ay",   32'(bus.SW_AY_O),    32'(mon_e.ay));
                chk("sb_data", 32'(bus.SW_DATA_O),  32'(mon_e.d));
                chk("sb_clr",  32'(bus.SW_CLEAR_O), 32'(mon_e.clr));
                n_pops++;
            end
        end
        prev_en <= bus.SW_EN_OS;
    end

    task automatic send(input logic [11:0] c, input bit will_issue);
        @(negedge clk);
        bus.CMD_VALID_I = 1'b1;
        bus.CMD_I       = c;
        if (will_issue) sb.push_back(mk(c));
        @(posedge clk);
        #1 bus.CMD_VALID_I = 1'b0;
    endtask

    task automatic wait_sb(input string tag, input int lim);
        int n = 0;
        while (sb.size() != 0 && n < lim) begin
            @(posedge clk); #1 n++;
        end
        chk(tag, 32'(n < lim), 32'h1);
    endtask

    task automatic wait_idle(input string tag, input int lim);
        int n = 0;
        while ((!bus.IDLE_O || sb.size() != 0) && n < lim) begin
            @(posedge clk); #1 n++;
        end
        chk(tag, 32'(n < lim), 32'h1);
    endtask

    task automatic reset_checks(input string pfx);
        chk({pfx, "_en"},    32'(bus.SW_EN_OS),    32'h0);
        chk({pfx, "_clr"},   32'(bus.SW_CLEAR_O),  32'h0);
        chk({pfx, "_ax"},    32'(bus.SW_AX_O),     32'h0);
        chk({pfx, "_ay"},    32'(bus.SW_AY_O),     32'h0);
        chk({pfx, "_data"},  32'(bus.SW_DATA_O),   32'h0);
        chk({pfx, "_err"},   32'(bus.ERR_O),       32'h0);
        chk({pfx, "_done"},  32'(bus.DONE_CNT_O),  32'h0);
        chk({pfx, "_idle"},  32'(bus.IDLE_O),      32'h1);
        chk({pfx, "_ready"}, 32'(bus.CMD_READY_O), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] base;
        int          pops0, lat;
        logic [11:0] c;

        bus.CMD_VALID_I = 1'b0;
        bus.CMD_I       = '0;
        bus.SW_IDLE_IS  = 6'h3F;
        #12 reset_checks("rst");
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // single command to chip 0, latency and held bus
        send(12'h0A5, 1'b1);
        lat = 0;
        while (bus.SW_EN_OS == '0 && lat < 20) begin
            @(posedge clk); #1 lat++;
        end
        chk("t1_latency", 32'(lat), 32'd2);
        bus.SW_IDLE_IS = 6'h3E;
        repeat (6) @(posedge clk);
        #1;
        chk("t1_done_busy", 32'(bus.DONE_CNT_O), 32'd0);
        chk("t1_ax_hold",   32'(bus.SW_AX_O),    32'hA);
        chk("t1_ay_hold",   32'(bus.SW_AY_O),    32'h2);
        chk("t1_d_hold",    32'(bus.SW_DATA_O),  32'h1);
        bus.SW_IDLE_IS = 6'h3F;
        wait_idle("t1_drain", 50);
        chk("t1_done",    32'(bus.DONE_CNT_O), 32'd1);
        chk("t1_ax_keep", 32'(bus.SW_AX_O),    32'hA);

        // broadcast clear
        send(12'hF00, 1'b1);
        wait_sb("t2_issue", 50);
        chk("t2_clr", 32'(bus.SW_CLEAR_O), 32'h1);
        bus.SW_IDLE_IS = 6'h00;
        repeat (5) @(posedge clk);
        #1 chk("t2_done_busy", 32'(bus.DONE_CNT_O), 32'd1);
        bus.SW_IDLE_IS = 6'h3F;
        wait_idle("t2_drain", 50);
        chk("t2_done", 32'(bus.DONE_CNT_O), 32'd2);

        // fill the queue with all drivers busy
        bus.SW_IDLE_IS = 6'h00;
        base  = bus.DONE_CNT_O;
        pops0 = n_pops;
        for (int i = 0; i < 8; i++) begin
            c = {3'(i % 6), 1'b0, 4'(i + 3), 3'(i), 1'(i)};
            @(negedge clk);
            bus.CMD_VALID_I = 1'b1;
            bus.CMD_I       = c;
            sb.push_back(mk(c));
            @(posedge clk);
            #1 chk("t3_ready", 32'(bus.CMD_READY_O), 32'(i < 7));
        end
        bus.CMD_I = 12'h0FF;
        repeat (4) begin
            @(posedge clk);
            #1 chk("t3_ready_full", 32'(bus.CMD_READY_O), 32'h0);
        end
        bus.CMD_VALID_I = 1'b0;
        chk("t3_no_enable", 32'(n_pops - pops0), 32'd0);
        bus.SW_IDLE_IS = 6'h3F;
        wait_idle("t3_drain", 500);
        chk("t3_done", 32'(bus.DONE_CNT_O - base), 32'd8);
        chk("t3_pops", 32'(n_pops - pops0),        32'd8);
        chk("t3_ready_back", 32'(bus.CMD_READY_O), 32'h1);

        // invalid chip index is discarded
        chk("t4_err_pre", 32'(bus.ERR_O), 32'h0);
        base  = bus.DONE_CNT_O;
        pops0 = n_pops;
        send({3'd6, 1'b0, 4'h3, 3'd1, 1'b1}, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("t4_err",  32'(bus.ERR_O),      32'h1);
        chk("t4_done", 32'(bus.DONE_CNT_O), 32'(base));
        chk("t4_pops", 32'(n_pops - pops0), 32'd0);
        send({3'd5, 1'b0, 4'h9, 3'd6, 1'b0}, 1'b1);
        wait_idle("t4_drain", 50);
        chk("t4_done_next", 32'(bus.DONE_CNT_O), 32'(base + 16'd1));
        chk("t4_err_stick", 32'(bus.ERR_O),      32'h1);

        // reset while waiting on a busy driver, with another command queued
        send({3'd1, 1'b0, 4'h7, 3'd3, 1'b1}, 1'b1);
        wait_sb("t5_issue", 50);
        bus.SW_IDLE_IS = 6'h3D;
        send({3'd0, 1'b0, 4'h5, 3'd5, 1'b1}, 1'b0);
        repeat (3) @(posedge clk);
        pops0 = n_pops;
        @(negedge clk) rst_n = 1'b0;
        #1 reset_checks("t5_rst");
        bus.SW_IDLE_IS = 6'h3F;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("t5_no_enable", 32'(n_pops - pops0),   32'd0);
        chk("t5_idle",      32'(bus.IDLE_O),       32'h1);
        chk("t5_done",      32'(bus.DONE_CNT_O),   32'd0);
        chk("t5_ready",     32'(bus.CMD_READY_O),  32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
